axi4_stream_layer_connector: RTL and testbench
==============================================

AXI4_STREAM_LAYER_CONNECTOR -- requirements
Module: axi4_stream_layer_connector

Interface
REQ-001 SHALL have parameter N_CH, default 18, number of activation channels per layer (2..256).
REQ-002 SHALL have parameter DATA_W, default 32, activation width in bits.
REQ-003 SHALL have parameter RELU, default 0; when 1, each captured activation is clamped as a signed value, so negative becomes 0.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port in_data, input, N_CH*DATA_W, packed activations; channel i at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port in_done, input, N_CH, per-channel done; bit i belongs to channel i.
REQ-009 SHALL have port in_ack, output, 1, one-cycle pulse on frame capture.
REQ-010 SHALL have port m_tdata, output, DATA_W, stream data.
REQ-011 SHALL have port m_tvalid, output, 1, stream valid.
REQ-012 SHALL have port m_tready, input, 1, stream ready.
REQ-013 SHALL have port m_tlast, output, 1, marks channel N_CH-1.
REQ-014 SHALL have port busy, output, 1, high while in SEND.
REQ-015 SHALL have port overrun, output, 1, sticky dropped-frame flag.
REQ-016 SHALL have port frame_cnt, output, 16, count of completed frames.

Function
REQ-017 all_done SHALL be the AND of all in_done bits; a partial set SHALL never start a frame.
REQ-018 An internal armed bit SHALL be set in any cycle where all_done=0, and cleared on a trigger.
REQ-019 A trigger SHALL occur on a clock edge where all_done=1 and armed=1, giving one trigger per rising edge of all_done.
REQ-020 FSM states SHALL be IDLE and SEND only.
REQ-021 On a trigger in IDLE, the block SHALL, on that edge, snapshot all N_CH channels (after ReLU if RELU=1), set idx=0, enter SEND, and pulse in_ack for one cycle.
REQ-022 m_tvalid SHALL be registered and go high on the trigger edge, so first data is visible one cycle after all_done is sampled high.
REQ-023 In SEND, m_tvalid SHALL be 1, m_tdata SHALL be snapshot[idx], and m_tlast SHALL equal (idx==N_CH-1).
REQ-024 A beat SHALL transfer on an edge with m_tvalid & m_tready; idx SHALL then increment by 1.
REQ-025 While m_tvalid=1 and m_tready=0, m_tdata, m_tlast and idx SHALL hold stable; m_tvalid SHALL NOT drop.
REQ-026 On the transfer of the tlast beat, the block SHALL return to IDLE, deassert m_tvalid on the same edge, and increment frame_cnt.
REQ-027 frame_cnt SHALL wrap from 65535 to 0.
REQ-028 Back-to-back frames SHALL be allowed: a trigger can occur in the first IDLE cycle after tlast.
REQ-029 A trigger in SEND SHALL NOT be captured; it SHALL set overrun (sticky until reset) and clear armed, and the current frame SHALL continue unchanged.
REQ-030 Snapshot contents SHALL be independent of in_data changes after capture.
REQ-031 Throughput with m_tready=1 SHALL be one beat per cycle: N_CH cycles per frame.
REQ-032 busy SHALL equal (state==SEND).
REQ-033 Index width SHALL be clog2(N_CH), with no wrap past N_CH-1.

Reset
REQ-034 With reset=1 on a clock edge, state SHALL be IDLE and idx, m_tvalid, m_tlast, m_tdata, in_ack, busy, overrun, frame_cnt and armed SHALL all be 0.
REQ-035 Reset mid-frame SHALL abort the frame: m_tvalid=0 after that edge, and no partial frame resumes.
REQ-036 Because armed resets to 0, all_done held high through reset SHALL NOT trigger until all_done has been seen low.

Verification
REQ-037 (Basic frame) N_CH=18, DATA_W=32, channel i=i, m_tready=1, all in_done raised -> 18 consecutive beats 0..17, tlast only on 17, one in_ack pulse, frame_cnt=1.
REQ-038 (Backpressure) Same stimulus, m_tready toggling each cycle -> identical sequence 0..17, and data/tlast stable during stalls.
REQ-039 (Rearm) Hold in_done high after frame 1 -> no further beats; drop in_done 1 cycle then raise -> second frame 0..17, frame_cnt=2.
REQ-040 (Partial done and overrun) Raise 17 of 18 done bits -> m_tvalid stays 0. During SEND with m_tready=0, drop and re-raise all done -> overrun=1, the frame completes with original data, and no extra frame follows.
REQ-041 (ReLU) RELU=1, channel 3 = 32'hFFFFFFF6 -> beat 3 = 0; channel 5 = 32'h7FFFFFFF -> beat 5 unchanged.
REQ-042 (Reset mid-frame) Assert reset after beat 7 -> m_tvalid=0, frame_cnt=0, overrun=0 next cycle; a fresh all_done edge then gives beats 0..17.

Source files
------------

// File: rtl/axi4_stream_layer_connector.sv
// Collects one activation per channel once every channel reports done, then
// streams the captured frame out over AXI4-Stream, one channel per beat.
module axi4_stream_layer_connector #(
    parameter int unsigned N_CH   = 18,
    parameter int unsigned DATA_W = 32,
    parameter bit          RELU   = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_done,
    output logic                     in_ack,
    output logic [DATA_W-1:0]        m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tlast,
    output logic                     busy,
    output logic                     overrun,
    output logic [15:0]              frame_cnt
);

    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_inc;
    logic                r_armed;
    logic                r_tvalid;
    logic                r_tlast;
    logic [DATA_W-1:0]   r_tdata;
    logic                r_ack;
    logic                r_overrun;
    logic [15:0]         r_frame_cnt;
    logic [DATA_W-1:0]   r_snap [N_CH];
    logic [DATA_W-1:0]   w_act  [N_CH];
    logic                w_all_done;
    logic                w_trigger;
    logic                w_beat;
    logic                w_capture;
    logic                w_last_beat;

    function automatic logic [DATA_W-1:0] relu_clamp(input logic [DATA_W-1:0] x);
        if (RELU && x[DATA_W-1]) begin
            return '0;
        end
        return x;
    endfunction

    assign w_all_done = &in_done;
    assign w_trigger  = w_all_done & r_armed;
    assign w_beat     = r_tvalid & m_tready;
    assign w_idx_inc  = r_idx + IDX_W'(1);

    // Per-channel activation after optional clamp
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_act[i] = relu_clamp(in_data[i*DATA_W +: DATA_W]);
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_last_beat  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_state_next = SEND;
                    w_capture    = 1'b1;
                end
            end
            SEND: begin
                if (w_beat && (r_idx == LAST_IDX)) begin
                    w_state_next = IDLE;
                    w_last_beat  = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Frame snapshot; contents only matter while SEND is active
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_snap[i] <= w_act[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_armed     <= 1'b0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tdata     <= '0;
            r_ack       <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_capture;

            // Re-arm only after all_done has been seen low
            if (!w_all_done) begin
                r_armed <= 1'b1;
            end else if (w_trigger) begin
                r_armed <= 1'b0;
            end

            if (w_trigger && (r_state == SEND)) begin
                r_overrun <= 1'b1;
            end

            if (w_capture) begin
                r_idx    <= '0;
                r_tvalid <= 1'b1;
                r_tdata  <= w_act[0];
                r_tlast  <= (LAST_IDX == '0);
            end else if (w_last_beat) begin
                r_idx       <= '0;
                r_tvalid    <= 1'b0;
                r_tlast     <= 1'b0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else if (w_beat) begin
                r_idx   <= w_idx_inc;
                r_tdata <= r_snap[w_idx_inc];
                r_tlast <= (w_idx_inc == LAST_IDX);
            end
        end
    end

    assign in_ack    = r_ack;
    assign m_tdata   = r_tdata;
    assign m_tvalid  = r_tvalid;
    assign m_tlast   = r_tlast;
    assign busy      = (r_state == SEND);
    assign overrun   = r_overrun;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_axi4_stream_layer_connector.sv
// Directed bench for axi4_stream_layer_connector: capture, streaming,
// backpressure, re-arm, overrun, back-to-back frames, ReLU and reset.
module tb_axi4_stream_layer_connector;

    localparam int unsigned N_CH   = 18;
    localparam int unsigned DATA_W = 32;
    localparam logic [N_CH-1:0] ALL_DONE = '1;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        in_done;
    logic                   in_ack;
    logic [DATA_W-1:0]      m_tdata;
    logic                   m_tvalid;
    logic                   m_tready;
    logic                   m_tlast;
    logic                   busy;
    logic                   overrun;
    logic [15:0]            frame_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] q_data[$];
    logic        q_last[$];
    int c_beats, c_cycles, c_first, c_acks, c_stall, c_to;

    always #5 clk = ~clk;

    axi4_stream_layer_connector #(
        .N_CH  (N_CH),
        .DATA_W(DATA_W),
        .RELU  (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_done  (in_done),
        .in_ack   (in_ack),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .busy     (busy),
        .overrun  (overrun),
        .frame_cnt(frame_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int base);
        for (int i = 0; i < N_CH; i++) begin
            in_data[i*DATA_W +: DATA_W] = 32'(base + i);
        end
    endtask

    // Drives m_tready, records accepted beats until tlast or budget expiry
    task automatic collect(input int mode, input int budget);
        logic        pv;
        logic        pl;
        logic [31:0] pd;
        logic        done_now;
        q_data.delete();
        q_last.delete();
        c_cycles = 0; c_first = -1; c_acks = 0; c_stall = 0; c_to = 0;
        pv = 1'b0; pl = 1'b0; pd = '0;
        forever begin
            m_tready = (mode == 0) ? 1'b1 : 1'(c_cycles & 1);
            if (in_ack) c_acks++;
            if (m_tvalid && c_first < 0) c_first = c_cycles;
            if (pv && (!m_tvalid || m_tdata !== pd || m_tlast !== pl)) c_stall++;
            pv = m_tvalid && !m_tready;
            pd = m_tdata;
            pl = m_tlast;
            done_now = m_tvalid && m_tready && m_tlast;
            if (m_tvalid && m_tready) begin
                q_data.push_back(m_tdata);
                q_last.push_back(m_tlast);
            end
            tick();
            c_cycles++;
            if (done_now) break;
            if (c_cycles >= budget) begin
                c_to = 1;
                break;
            end
        end
        c_beats = q_data.size();
    endtask

    task automatic test_reset();
        int nv;
        reset = 1'b1; in_done = ALL_DONE; m_tready = 1'b1; set_data(0);
        tick(); tick();
        n_cmp++; if ({m_tvalid, m_tlast, in_ack, busy, overrun} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags got %b want 00000", {m_tvalid, m_tlast, in_ack, busy, overrun}); end
        n_cmp++; if (m_tdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_tdata got %h want 0", m_tdata); end
        n_cmp++; if (frame_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
        reset = 1'b0;
        nv = 0;
        repeat (6) begin tick(); if (m_tvalid) nv++; end
        n_cmp++; if (nv !== 0) begin
            n_fail++; $display("FAIL reset_held_done got %0d valid cycles want 0", nv); end
        in_done = '0; tick();
    endtask

    task automatic test_partial_done();
        int nv;
        in_done = 18'h1FFFF;
        nv = 0;
        repeat (6) begin tick(); if (m_tvalid || in_ack) nv++; end
        n_cmp++; if (nv !== 0) begin
            n_fail++; $display("FAIL partial_done got %0d active cycles want 0", nv); end
        in_done = '0; tick();
    endtask

    task automatic test_basic_frame();
        set_data(0);
        in_done = ALL_DONE;
        collect(0, 40);
        n_cmp++; if (c_to !== 0 || c_beats !== 18) begin
            n_fail++; $display("FAIL basic_beats got %0d (timeout %0d) want 18", c_beats, c_to); end
        for (int i = 0; i < c_beats && i < 18; i++) begin
            n_cmp++; if (q_data[i] !== 32'(i) || q_last[i] !== (i == 17)) begin
                n_fail++; $display("FAIL basic_beat%0d got %h/%b want %h/%b", i, q_data[i], q_last[i], i, (i == 17)); end
        end
        n_cmp++; if (c_first !== 1 || c_cycles !== 19) begin
            n_fail++; $display("FAIL basic_timing got first %0d cycles %0d want 1 19", c_first, c_cycles); end
        n_cmp++; if (c_acks !== 1) begin
            n_fail++; $display("FAIL basic_ack got %0d pulses want 1", c_acks); end
        n_cmp++; if (frame_cnt !== 16'd1 || m_tvalid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_end got cnt %0d valid %b busy %b want 1 0 0", frame_cnt, m_tvalid, busy); end
    endtask

    task automatic test_rearm();
        int nv;
        nv = 0;
        m_tready = 1'b1;
        repeat (10) begin tick(); if (m_tvalid) nv++; end
        n_cmp++; if (nv !== 0) begin
            n_fail++; $display("FAIL rearm_hold got %0d valid cycles want 0", nv); end
        in_done = '0; tick();
        in_done = ALL_DONE;
        collect(0, 40);
        n_cmp++; if (c_beats !== 18) begin
            n_fail++; $display("FAIL rearm_beats got %0d want 18", c_beats); end
        for (int i = 0; i < c_beats && i < 18; i++) begin
            n_cmp++; if (q_data[i] !== 32'(i)) begin
                n_fail++; $display("FAIL rearm_beat%0d got %h want %h", i, q_data[i], i); end
        end
        n_cmp++; if (frame_cnt !== 16'd2) begin
            n_fail++; $display("FAIL rearm_cnt got %0d want 2", frame_cnt); end
    endtask

    task automatic test_backpressure();
        in_done = '0; tick();
        in_done = ALL_DONE;
        collect(1, 80);
        n_cmp++; if (c_to !== 0 || c_beats !== 18) begin
            n_fail++; $display("FAIL bp_beats got %0d (timeout %0d) want 18", c_beats, c_to); end
        for (int i = 0; i < c_beats && i < 18; i++) begin
            n_cmp++; if (q_data[i] !== 32'(i) || q_last[i] !== (i == 17)) begin
                n_fail++; $display("FAIL bp_beat%0d got %h/%b want %h/%b", i, q_data[i], q_last[i], i, (i == 17)); end
        end
        n_cmp++; if (c_stall !== 0) begin
            n_fail++; $display("FAIL bp_stall_stable got %0d violations want 0", c_stall); end
        n_cmp++; if (frame_cnt !== 16'd3) begin
            n_fail++; $display("FAIL bp_cnt got %0d want 3", frame_cnt); end
    endtask

    task automatic test_overrun();
        int nv;
        in_done = '0; tick();
        set_data(100);
        m_tready = 1'b0;
        in_done = ALL_DONE; tick();
        tick();
        in_done = '0; tick();
        set_data(500);
        in_done = ALL_DONE; tick();
        n_cmp++; if (overrun !== 1'b1 || in_ack !== 1'b0) begin
            n_fail++; $display("FAIL overrun_flag got ovr %b ack %b want 1 0", overrun, in_ack); end
        n_cmp++; if (m_tdata !== 32'd100 || busy !== 1'b1) begin
            n_fail++; $display("FAIL overrun_hold got %h busy %b want 64 1", m_tdata, busy); end
        collect(0, 40);
        n_cmp++; if (c_beats !== 18 || c_acks !== 0) begin
            n_fail++; $display("FAIL overrun_beats got %0d acks %0d want 18 0", c_beats, c_acks); end
        for (int i = 0; i < c_beats && i < 18; i++) begin
            n_cmp++; if (q_data[i] !== 32'(100 + i)) begin
                n_fail++; $display("FAIL overrun_beat%0d got %h want %h", i, q_data[i], 100 + i); end
        end
        nv = 0;
        repeat (10) begin tick(); if (m_tvalid) nv++; end
        n_cmp++; if (nv !== 0 || frame_cnt !== 16'd4 || overrun !== 1'b1) begin
            n_fail++; $display("FAIL overrun_after got valid %0d cnt %0d ovr %b want 0 4 1", nv, frame_cnt, overrun); end
    endtask

    task automatic test_back_to_back();
        in_done = '0; tick();
        set_data(0);
        in_done = ALL_DONE; tick();
        in_done = '0;
        collect(0, 40);
        n_cmp++; if (c_beats !== 18 || c_acks !== 1) begin
            n_fail++; $display("FAIL b2b_first got %0d beats %0d acks want 18 1", c_beats, c_acks); end
        in_done = ALL_DONE;
        collect(0, 40);
        n_cmp++; if (c_beats !== 18 || c_first !== 1 || c_cycles !== 19) begin
            n_fail++; $display("FAIL b2b_second got beats %0d first %0d cycles %0d want 18 1 19", c_beats, c_first, c_cycles); end
        n_cmp++; if (c_beats == 18 && (q_data[0] !== 32'd0 || q_data[17] !== 32'd17)) begin
            n_fail++; $display("FAIL b2b_data got %h..%h want 0..11", q_data[0], q_data[17]); end
        n_cmp++; if (frame_cnt !== 16'd6) begin
            n_fail++; $display("FAIL b2b_cnt got %0d want 6", frame_cnt); end
    endtask

    task automatic test_relu();
        in_done = '0; tick();
        set_data(0);
        in_data[3*DATA_W +: DATA_W] = 32'hFFFF_FFF6;
        in_data[5*DATA_W +: DATA_W] = 32'h7FFF_FFFF;
        in_done = ALL_DONE;
        collect(0, 40);
        n_cmp++; if (c_beats !== 18) begin
            n_fail++; $display("FAIL relu_beats got %0d want 18", c_beats); end
        if (c_beats == 18) begin
            n_cmp++; if (q_data[3] !== 32'd0) begin
                n_fail++; $display("FAIL relu_neg got %h want 0", q_data[3]); end
            n_cmp++; if (q_data[5] !== 32'h7FFF_FFFF || q_data[2] !== 32'd2) begin
                n_fail++; $display("FAIL relu_pos got %h/%h want 7fffffff/2", q_data[5], q_data[2]); end
        end
        n_cmp++; if (frame_cnt !== 16'd7) begin
            n_fail++; $display("FAIL relu_cnt got %0d want 7", frame_cnt); end
    endtask

    task automatic test_reset_midframe();
        int nv;
        in_done = '0; tick();
        set_data(0);
        m_tready = 1'b1;
        in_done = ALL_DONE; tick();
        repeat (8) tick();
        n_cmp++; if (m_tdata !== 32'd8 || m_tvalid !== 1'b1) begin
            n_fail++; $display("FAIL midframe_pos got %h valid %b want 8 1", m_tdata, m_tvalid); end
        reset = 1'b1; tick();
        n_cmp++; if (m_tvalid !== 1'b0 || frame_cnt !== 16'd0 || overrun !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midframe_reset got valid %b cnt %0d ovr %b busy %b want 0 0 0 0", m_tvalid, frame_cnt, overrun, busy); end
        reset = 1'b0;
        nv = 0;
        repeat (5) begin tick(); if (m_tvalid) nv++; end
        n_cmp++; if (nv !== 0) begin
            n_fail++; $display("FAIL midframe_no_resume got %0d valid cycles want 0", nv); end
        in_done = '0; tick();
        in_done = ALL_DONE;
        collect(0, 40);
        n_cmp++; if (c_beats !== 18) begin
            n_fail++; $display("FAIL midframe_fresh got %0d beats want 18", c_beats); end
        for (int i = 0; i < c_beats && i < 18; i++) begin
            n_cmp++; if (q_data[i] !== 32'(i)) begin
                n_fail++; $display("FAIL midframe_beat%0d got %h want %h", i, q_data[i], i); end
        end
        n_cmp++; if (frame_cnt !== 16'd1) begin
            n_fail++; $display("FAIL midframe_cnt got %0d want 1", frame_cnt); end
    endtask

    initial begin
        reset = 1'b1; in_done = '0; m_tready = 1'b0; in_data = '0;
        test_reset();
        test_partial_done();
        test_basic_frame();
        test_rearm();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_relu();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
